// File: rtl/bp_be_prefetch_scheduler_pkg.sv
// bp_be_pkg: shared types for the backend prefetch scheduler.
//   - bp_params_e / bp_vaddr_width(): processor config lookup for vaddr width
//   - bp_be_pf_state_e: scheduler FSM states
//   - `DECLARE_BP_BE_PF_STREAM_S: packed stream record {pc, addr, stride, remaining}

`define DECLARE_BP_BE_PF_STREAM_S(vaddr_width_mp, eaddr_width_mp, degree_width_mp) \
  typedef struct packed {                                                         \
    logic [vaddr_width_mp-1:0]  pc;                                               \
    logic [eaddr_width_mp-1:0]  addr;                                             \
    logic [eaddr_width_mp-1:0]  stride;                                           \
    logic [degree_width_mp-1:0] remaining;                                        \
  } bp_be_pf_stream_s

package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg
  } bp_params_e;

  localparam int bp_default_vaddr_width_gp = 39;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_default_vaddr_width_gp;
      default:          return bp_default_vaddr_width_gp;
    endcase
  endfunction

  typedef enum logic [0:0] {
    e_idle,
    e_issue
  } bp_be_pf_state_e;

endpackage

// File: rtl/bp_be_prefetch_scheduler_fifo.sv
// bsg_fifo_1r1w_small: small register-based FIFO holding pending streams.
//   clk_i, reset_i : clock, asynchronous active-high reset (empties the FIFO)
//   v_i, data_i    : write request/data, accepted when ready_o
//   ready_o        : not full
//   v_o, data_o    : head valid/data
//   yumi_i         : consumer pops the head (only when v_o)

module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int count_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]        mem_q [els_p];
    logic [ptr_width_lp-1:0]   wptr_q, rptr_q, wptr_d, rptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      enq, deq;

    assign ready_o = (count_q != count_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (enq) begin
            wptr_d = (wptr_q == ptr_width_lp'(els_p - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (deq) begin
            rptr_d = (rptr_q == ptr_width_lp'(els_p - 1)) ? '0 : rptr_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_be_prefetch_scheduler.sv
// bp_be_prefetch_scheduler: queues confirmed stride streams and walks each one
// for prefetch_degree_p strides, issuing one block address per handshake and
// silently skipping addresses in the same block as the last issued one.
//   clk_i, reset_i          : clock, asynchronous active-high reset
//   start_discovery_i, pc_i : detector retraining pc_i; cancels a matching active stream
//   confirm_discovery_i     : enqueue {pc_i, eff_addr_i+stride, stride, degree}
//   eff_addr_i, stride_i    : latest effective address, signed stride
//   flush_i                 : drop all queued/active prefetch state
//   pf_v_o, pf_addr_o       : prefetch request, accepted with pf_ready_and_i
//   busy_o                  : stream active or queue non-empty
//   dropped_o               : one-cycle pulse, confirm dropped on full queue

module bp_be_prefetch_scheduler
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  localparam int vaddr_width_p      = bp_vaddr_width(bp_params_p),
  parameter int stride_width_p         = 8,
  parameter int effective_addr_width_p = vaddr_width_p,
  parameter int prefetch_degree_p      = 4,
  parameter int queue_els_p            = 4,
  parameter int block_offset_width_p   = 6
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              start_discovery_i,
  input  logic                              confirm_discovery_i,
  input  logic [vaddr_width_p-1:0]          pc_i,
  input  logic [effective_addr_width_p-1:0] eff_addr_i,
  input  logic [stride_width_p-1:0]         stride_i,
  input  logic                              flush_i,
  output logic                              pf_v_o,
  output logic [effective_addr_width_p-1:0] pf_addr_o,
  input  logic                              pf_ready_and_i,
  output logic                              busy_o,
  output logic                              dropped_o
);

  localparam int degree_width_lp = $clog2(prefetch_degree_p + 1);
  localparam int blk_width_lp    = effective_addr_width_p - block_offset_width_p;

  `DECLARE_BP_BE_PF_STREAM_S(vaddr_width_p, effective_addr_width_p, degree_width_lp);
  localparam int stream_width_lp = $bits(bp_be_pf_stream_s);

  bp_be_pf_state_e state_q, state_d;
  bp_be_pf_stream_s cur_q, cur_d;
  logic [blk_width_lp-1:0] last_blk_q, last_blk_d;
  logic last_v_q, last_v_d;
  logic dropped_q, dropped_d;

  logic [effective_addr_width_p-1:0] stride_ext;
  logic [blk_width_lp-1:0] cur_blk;
  bp_be_pf_stream_s enq_entry, head_entry;
  logic [stream_width_lp-1:0] fifo_data_lo;
  logic confirm_v, fifo_ready, fifo_v, fifo_yumi, fifo_reset;
  logic issuing, dup, handshake, advance, cancel;

  assign stride_ext = {{(effective_addr_width_p - stride_width_p){stride_i[stride_width_p-1]}},
                       stride_i};

  assign enq_entry = '{pc:        pc_i,
                       addr:      eff_addr_i + stride_ext,
                       stride:    stride_ext,
                       remaining: degree_width_lp'(prefetch_degree_p)};

  assign confirm_v  = confirm_discovery_i & (|stride_i) & ~flush_i;
  assign fifo_reset = reset_i | flush_i;

  bsg_fifo_1r1w_small #(
    .width_p (stream_width_lp),
    .els_p   (queue_els_p)
  ) stream_queue (
    .clk_i   (clk_i),
    .reset_i (fifo_reset),
    .v_i     (confirm_v),
    .data_i  (enq_entry),
    .ready_o (fifo_ready),
    .v_o     (fifo_v),
    .data_o  (fifo_data_lo),
    .yumi_i  (fifo_yumi)
  );

  assign head_entry = fifo_data_lo;

  assign issuing   = (state_q == e_issue);
  assign cur_blk   = cur_q.addr[effective_addr_width_p-1:block_offset_width_p];
  assign dup       = last_v_q & (cur_blk == last_blk_q);
  assign pf_v_o    = issuing & ~dup;
  assign pf_addr_o = cur_q.addr;
  assign busy_o    = issuing | fifo_v;
  assign dropped_o = dropped_q;

  assign handshake = pf_v_o & pf_ready_and_i;
  assign advance   = issuing & (handshake | dup);
  assign cancel    = issuing & start_discovery_i & (pc_i == cur_q.pc);

  // Flush beats cancel beats advance/pop; a handshake coincident with a
  // cancel still records its block for dedup.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_blk_d = last_blk_q;
    last_v_d   = last_v_q;
    fifo_yumi  = 1'b0;
    dropped_d  = confirm_v & ~fifo_ready;

    if (flush_i) begin
      state_d  = e_idle;
      last_v_d = 1'b0;
    end else begin
      if (handshake) begin
        last_blk_d = cur_blk;
        last_v_d   = 1'b1;
      end
      if (cancel) begin
        state_d = e_idle;
      end else begin
        case (state_q)
          e_idle: begin
            if (fifo_v) begin
              fifo_yumi = 1'b1;
              cur_d     = head_entry;
              state_d   = e_issue;
            end
          end
          e_issue: begin
            if (advance) begin
              cur_d.addr      = cur_q.addr + cur_q.stride;
              cur_d.remaining = cur_q.remaining - 1'b1;
              if (cur_q.remaining == degree_width_lp'(1)) begin
                if (fifo_v) begin
                  fifo_yumi = 1'b1;
                  cur_d     = head_entry;
                end else begin
                  state_d = e_idle;
                end
              end
            end
          end
          default: state_d = e_idle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= e_idle;
      cur_q      <= '0;
      last_blk_q <= '0;
      last_v_q   <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      last_blk_q <= last_blk_d;
      last_v_q   <= last_v_d;
      dropped_q  <= dropped_d;
    end
  end

endmodule

// File: tb/tb_bp_be_prefetch_scheduler.sv
// Table-driven bench for bp_be_prefetch_scheduler (default 39-bit addresses).
// Each row: inputs applied for one cycle plus outputs expected during that
// cycle (sampled on the falling edge before the inputs are changed).

module tb_bp_be_prefetch_scheduler;

    localparam int EAW = 39;

    logic            clk = 1'b0;
    logic            reset_i = 1'b0;
    logic            start_discovery_i = 1'b0;
    logic            confirm_discovery_i = 1'b0;
    logic [EAW-1:0]  pc_i = '0;
    logic [EAW-1:0]  eff_addr_i = '0;
    logic [7:0]      stride_i = '0;
    logic            flush_i = 1'b0;
    logic            pf_ready_and_i = 1'b0;
    logic            pf_v_o;
    logic [EAW-1:0]  pf_addr_o;
    logic            busy_o;
    logic            dropped_o;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bp_be_prefetch_scheduler dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .start_discovery_i   (start_discovery_i),
        .confirm_discovery_i (confirm_discovery_i),
        .pc_i                (pc_i),
        .eff_addr_i          (eff_addr_i),
        .stride_i            (stride_i),
        .flush_i             (flush_i),
        .pf_v_o              (pf_v_o),
        .pf_addr_o           (pf_addr_o),
        .pf_ready_and_i      (pf_ready_and_i),
        .busy_o              (busy_o),
        .dropped_o           (dropped_o)
    );

    typedef struct {
        logic           start, conf, flush, ready;
        logic [EAW-1:0] pc, ea;
        logic [7:0]     stride;
        logic           exp_v;
        logic [EAW-1:0] exp_addr;
        logic           exp_busy, exp_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic cf, input logic fl, input logic rd,
                                input logic [EAW-1:0] pc, input logic [EAW-1:0] ea,
                                input logic [7:0] sd, input logic ev, input logic [EAW-1:0] eaddr,
                                input logic eb, input logic ed);
        vec_t v;
        v.start = st; v.conf = cf; v.flush = fl; v.ready = rd;
        v.pc = pc; v.ea = ea; v.stride = sd;
        v.exp_v = ev; v.exp_addr = eaddr; v.exp_busy = eb; v.exp_drop = ed;
        vecs.push_back(v);
    endfunction

    function automatic void idle(input logic rd, input logic ev, input logic [EAW-1:0] eaddr,
                                 input logic eb, input logic ed);
        add(1'b0, 1'b0, 1'b0, rd, '0, '0, 8'h00, ev, eaddr, eb, ed);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Single stream, stride 0x40, ready held high.
        add(0, 1, 0, 1, 39'h100, 39'h1000, 8'h40, 0, 0, 0, 0);
        idle(1, 0, 0, 1, 0);
        idle(1, 1, 39'h1040, 1, 0);
        idle(1, 1, 39'h1080, 1, 0);
        idle(1, 1, 39'h10C0, 1, 0);
        idle(1, 1, 39'h1100, 1, 0);
        idle(1, 0, 0, 0, 0);
        // Sub-block stride: one request, three silent skips.
        add(0, 1, 0, 1, 39'h200, 39'h2000, 8'h08, 0, 0, 0, 0);
        idle(1, 0, 0, 1, 0);
        idle(1, 1, 39'h2008, 1, 0);
        idle(1, 0, 0, 1, 0);
        idle(1, 0, 0, 1, 0);
        idle(1, 0, 0, 1, 0);
        idle(1, 0, 0, 0, 0);
        // Backpressure for three cycles mid-stream.
        add(0, 1, 0, 1, 39'h300, 39'h3000, 8'h40, 0, 0, 0, 0);
        idle(1, 0, 0, 1, 0);
        idle(1, 1, 39'h3040, 1, 0);
        idle(0, 1, 39'h3080, 1, 0);
        idle(0, 1, 39'h3080, 1, 0);
        idle(0, 1, 39'h3080, 1, 0);
        idle(1, 1, 39'h3080, 1, 0);
        idle(1, 1, 39'h30C0, 1, 0);
        idle(1, 1, 39'h3100, 1, 0);
        idle(1, 0, 0, 0, 0);
        // Queue full: six confirms with ready low, sixth dropped.
        for (int i = 0; i < 6; i++)
            add(0, 1, 0, 0, 39'h400 + 39'(i), 39'h4000, 8'h40,
                (i >= 2), (i >= 2) ? 39'h4040 : 39'h0, (i >= 1), 0);
        idle(0, 1, 39'h4040, 1, 1);
        idle(0, 1, 39'h4040, 1, 0);
        // Flush with a confirm in the same cycle.
        add(0, 1, 1, 1, 39'h500, 39'h5000, 8'h40, 1, 39'h4040, 1, 0);
        idle(1, 0, 0, 0, 0);
        idle(1, 0, 0, 0, 0);
        // Flush coincident with a confirm that would otherwise be dropped.
        for (int i = 0; i < 6; i++)
            add(0, 1, (i == 5), 0, 39'h600 + 39'(i), 39'h6000, 8'h40,
                (i >= 2), (i >= 2) ? 39'h6040 : 39'h0, (i >= 1), 0);
        idle(0, 0, 0, 0, 0);
        // Cancel active stream; queued stream follows.
        add(0, 1, 0, 0, 39'h700, 39'h7000, 8'h40, 0, 0, 0, 0);
        add(0, 1, 0, 0, 39'h710, 39'h8000, 8'h40, 0, 0, 1, 0);
        add(1, 0, 0, 1, 39'h700, 0, 8'h00, 1, 39'h7040, 1, 0);
        idle(1, 0, 0, 1, 0);
        idle(1, 1, 39'h8040, 1, 0);
        idle(1, 1, 39'h8080, 1, 0);
        idle(1, 1, 39'h80C0, 1, 0);
        idle(1, 1, 39'h8100, 1, 0);
        idle(1, 0, 0, 0, 0);
        // Negative stride wrapping below zero.
        add(0, 1, 0, 1, 39'h910, 39'h40, 8'hC0, 0, 0, 0, 0);
        idle(1, 0, 0, 1, 0);
        idle(1, 1, 39'h0, 1, 0);
        idle(1, 1, 39'h7F_FFFF_FFC0, 1, 0);
        idle(1, 1, 39'h7F_FFFF_FF80, 1, 0);
        idle(1, 1, 39'h7F_FFFF_FF40, 1, 0);
        idle(1, 0, 0, 0, 0);
        // Negative stride without wrap.
        add(0, 1, 0, 1, 39'h900, 39'h100, 8'hC0, 0, 0, 0, 0);
        idle(1, 0, 0, 1, 0);
        idle(1, 1, 39'hC0, 1, 0);
        idle(1, 1, 39'h80, 1, 0);
        idle(1, 1, 39'h40, 1, 0);
        idle(1, 1, 39'h00, 1, 0);
        idle(1, 0, 0, 0, 0);

        // Reset state.
        #1 reset_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset pf_v", 64'(pf_v_o), 64'd0);
        check("reset pf_addr", 64'(pf_addr_o), 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset dropped", 64'(dropped_o), 64'd0);
        reset_i = 1'b0;

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check($sformatf("row%0d pf_v", i), 64'(pf_v_o), 64'(vecs[i].exp_v));
            if (vecs[i].exp_v)
                check($sformatf("row%0d pf_addr", i), 64'(pf_addr_o), 64'(vecs[i].exp_addr));
            check($sformatf("row%0d busy", i), 64'(busy_o), 64'(vecs[i].exp_busy));
            check($sformatf("row%0d dropped", i), 64'(dropped_o), 64'(vecs[i].exp_drop));
            start_discovery_i   = vecs[i].start;
            confirm_discovery_i = vecs[i].conf;
            flush_i             = vecs[i].flush;
            pf_ready_and_i      = vecs[i].ready;
            pc_i                = vecs[i].pc;
            eff_addr_i          = vecs[i].ea;
            stride_i            = vecs[i].stride;
        end

        // Asynchronous reset in the middle of an issuing stream.
        @(negedge clk);
        confirm_discovery_i = 1'b1;
        pc_i = 39'hA00; eff_addr_i = 39'hA000; stride_i = 8'h40; pf_ready_and_i = 1'b0;
        @(negedge clk);
        confirm_discovery_i = 1'b0;
        @(negedge clk);
        check("pre-reset pf_v", 64'(pf_v_o), 64'd1);
        check("pre-reset pf_addr", 64'(pf_addr_o), 64'h0000_A040);
        #2 reset_i = 1'b1;
        #1;
        check("async reset pf_v", 64'(pf_v_o), 64'd0);
        check("async reset pf_addr", 64'(pf_addr_o), 64'd0);
        check("async reset busy", 64'(busy_o), 64'd0);
        check("async reset dropped", 64'(dropped_o), 64'd0);
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        check("post-reset busy", 64'(busy_o), 64'd0);
        check("post-reset pf_v", 64'(pf_v_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
